// File: rtl/pio_button_if.sv
// Avalon-MM slave bus bundle for the button/switch PIO.
// The master drives the address and write strobes, and the slave returns readdata.
interface pio_button_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/pio_button.sv
// Button/switch PIO: synchronised inputs, per-bit edge capture, and a maskable level irq.
// Register map: 0 data, 1 reserved, 2 irq_mask, 3 edge_capture (write 1 to clear).
module pio_button #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    pio_button_if.slave      bus,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int ARM_MAX = SYNC_STAGES + 1;
    localparam int AW      = $clog2(ARM_MAX + 1);
    localparam logic [AW-1:0] ARM_LAST = AW'(ARM_MAX);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] ec_next;
    logic [AW-1:0]    arm_cnt;
    logic             armed;
    logic             wr_en;
    logic [31:0]      rd_mux;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign armed    = (arm_cnt == ARM_LAST);
    assign wr_en    = bus.chipselect & ~bus.write_n;

    // Metastability chain: the only logic that samples in_port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_q[i] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
        end
    end

    // One-cycle-delayed copy of sync_out for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            prev <= '0;
        else
            prev <= sync_out;
    end

    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign edge_det = sync_out & ~prev;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign edge_det = ~sync_out & prev;
        end else begin : g_any
            assign edge_det = sync_out ^ prev;
        end
    endgenerate

    // Arm counter: ignores the fake edges produced while the
    // chain fills with levels that were held through reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            arm_cnt <= '0;
        else if (!armed)
            arm_cnt <= arm_cnt + 1'b1;
    end

    // Clear and set merge; a newly detected edge wins over a clear.
    always_comb begin
        clr_mask = '0;
        if (wr_en && bus.address == 2'd3)
            clr_mask = bus.writedata[WIDTH-1:0];
        ec_next = (edge_capture & ~clr_mask)
                | (armed ? edge_det : '0);
    end

    // Edge capture register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            edge_capture <= '0;
        else
            edge_capture <= ec_next;
    end

    // Interrupt mask register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            irq_mask <= '0;
        else if (wr_en && bus.address == 2'd2)
            irq_mask <= bus.writedata[WIDTH-1:0];
    end

    // Read mux, zero-extended to the bus width.
    always_comb begin
        rd_mux = '0;
        unique case (bus.address)
            2'd0:    rd_mux[WIDTH-1:0] = sync_out;
            2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
            2'd3:    rd_mux[WIDTH-1:0] = edge_capture;
            default: rd_mux = '0;
        endcase
    end

    // Registered read data (one-cycle latency, no side effects).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            bus.readdata <= '0;
        else
            bus.readdata <= rd_mux;
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_pio_button.sv
// Testbench for pio_button: rising, falling, and any-edge instances share one stimulus stream.
// A delay-line reference model predicts readdata and irq on every cycle.
module tb_pio_button;

    localparam int S = 2;

    typedef struct {
        logic [1:0]  addr;
        logic        cs;
        logic        wn;
        logic [31:0] wd;
        logic [7:0]  inp;
        logic [31:0] erd;
        logic        eirq;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  addr = '0;
    logic        cs = 1'b0;
    logic        wn = 1'b1;
    logic [31:0] wd = '0;
    logic [7:0]  in_p = '0;
    logic [2:0]  irqv;
    logic [31:0] rdv [3];

    int total = 0;
    int bad = 0;

    int          n;
    logic [7:0]  hist [$];
    logic [7:0]  ec_m [3];
    logic [7:0]  mask_m;
    logic [31:0] erd [3];
    logic        eirq [3];

    vec_t tbl [18];

    always #5 clk = ~clk;

    pio_button_if bus0 ();
    pio_button_if bus1 ();
    pio_button_if bus2 ();

    assign bus0.address = addr;
    assign bus0.chipselect = cs;
    assign bus0.write_n = wn;
    assign bus0.writedata = wd;
    assign bus1.address = addr;
    assign bus1.chipselect = cs;
    assign bus1.write_n = wn;
    assign bus1.writedata = wd;
    assign bus2.address = addr;
    assign bus2.chipselect = cs;
    assign bus2.write_n = wn;
    assign bus2.writedata = wd;
    assign rdv[0] = bus0.readdata;
    assign rdv[1] = bus1.readdata;
    assign rdv[2] = bus2.readdata;

    pio_button #(.WIDTH(8), .SYNC_STAGES(S), .EDGE_TYPE(0)) dut (
        .clk(clk), .reset_n(rst_n), .bus(bus0),
        .in_port(in_p), .irq(irqv[0])
    );
    pio_button #(.WIDTH(8), .SYNC_STAGES(S), .EDGE_TYPE(1)) dut_fall (
        .clk(clk), .reset_n(rst_n), .bus(bus1),
        .in_port(in_p), .irq(irqv[1])
    );
    pio_button #(.WIDTH(8), .SYNC_STAGES(S), .EDGE_TYPE(2)) dut_any (
        .clk(clk), .reset_n(rst_n), .bus(bus2),
        .in_port(in_p), .irq(irqv[2])
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] get(input int j);
        if (j >= 1 && j <= hist.size())
            return hist[j-1];
        return 8'h00;
    endfunction

    task automatic model_reset();
        n = 0;
        hist.delete();
        mask_m = '0;
        for (int t = 0; t < 3; t++) begin
            ec_m[t] = '0;
            erd[t] = '0;
            eirq[t] = 1'b0;
        end
    endtask

    // Level seen at sync_out before edge n is the input from S edges earlier.
    task automatic model_step(input logic [1:0] a, input logic c, input logic w,
                              input logic [31:0] d, input logic [7:0] p);
        logic [7:0] cur, prv, e, clr;
        n++;
        hist.push_back(p);
        cur = get(n - S);
        prv = get(n - S - 1);
        clr = (c && !w && a == 2'd3) ? d[7:0] : 8'h00;
        for (int t = 0; t < 3; t++) begin
            if (t == 0) e = cur & ~prv;
            else if (t == 1) e = ~cur & prv;
            else e = cur ^ prv;
            case (a)
                2'd0: erd[t] = {24'h0, cur};
                2'd2: erd[t] = {24'h0, mask_m};
                2'd3: erd[t] = {24'h0, ec_m[t]};
                default: erd[t] = 32'h0;
            endcase
            ec_m[t] = (ec_m[t] & ~clr) | ((n > S + 1) ? e : 8'h00);
        end
        if (c && !w && a == 2'd2)
            mask_m = d[7:0];
        for (int t = 0; t < 3; t++)
            eirq[t] = |(ec_m[t] & mask_m);
    endtask

    task automatic step(input logic [1:0] a, input logic c, input logic w,
                        input logic [31:0] d, input logic [7:0] p);
        addr = a;
        cs = c;
        wn = w;
        wd = d;
        in_p = p;
        @(posedge clk);
        model_step(a, c, w, d, p);
        #1;
        for (int t = 0; t < 3; t++) begin
            check($sformatf("model_rd%0d", t), rdv[t], erd[t]);
            check($sformatf("model_irq%0d", t), {31'h0, irqv[t]}, {31'h0, eirq[t]});
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] p);
        step(a, 1'b1, 1'b1, 32'h0, p);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [7:0] p);
        step(a, 1'b1, 1'b0, d, p);
    endtask

    // Reset asserted mid-cycle; outputs must clear with no clock edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int t = 0; t < 3; t++) begin
            check($sformatf("rst_rd%0d", t), rdv[t], 32'h0);
            check($sformatf("rst_irq%0d", t), {31'h0, irqv[t]}, 32'h0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic [1:0] a, input logic w, input logic [31:0] d,
                                input logic [7:0] p, input logic [31:0] e, input logic q);
        vec_t v;
        v.addr = a;
        v.cs = 1'b1;
        v.wn = w;
        v.wd = d;
        v.inp = p;
        v.erd = e;
        v.eirq = q;
        return v;
    endfunction

    initial begin
        logic [7:0]  rp;
        logic [1:0]  ra;
        logic        rc;
        logic        rw;
        logic [31:0] rdat;

        for (int i = 0; i < 5; i++)
            tbl[i] = mk(2'd0, 1'b1, 32'h0, 8'h00, 32'h0, 1'b0);
        tbl[5]  = mk(2'd3, 1'b1, 32'h0, 8'h05, 32'h0, 1'b0);
        tbl[6]  = mk(2'd3, 1'b1, 32'h0, 8'h05, 32'h0, 1'b0);
        tbl[7]  = mk(2'd3, 1'b1, 32'h0, 8'h05, 32'h0, 1'b0);
        tbl[8]  = mk(2'd3, 1'b1, 32'h0, 8'h05, 32'h5, 1'b0);
        tbl[9]  = mk(2'd0, 1'b1, 32'h0, 8'h05, 32'h5, 1'b0);
        tbl[10] = mk(2'd2, 1'b0, 32'h1, 8'h05, 32'h0, 1'b1);
        tbl[11] = mk(2'd2, 1'b1, 32'h0, 8'h05, 32'h1, 1'b1);
        tbl[12] = mk(2'd3, 1'b0, 32'h1, 8'h05, 32'h5, 1'b0);
        tbl[13] = mk(2'd3, 1'b1, 32'h0, 8'h05, 32'h4, 1'b0);
        tbl[14] = mk(2'd1, 1'b1, 32'h0, 8'h05, 32'h0, 1'b0);
        tbl[15] = mk(2'd1, 1'b0, 32'hFFFF_FFFF, 8'h05, 32'h0, 1'b0);
        tbl[16] = mk(2'd0, 1'b0, 32'hFF, 8'h05, 32'h5, 1'b0);
        tbl[17] = mk(2'd2, 1'b1, 32'h0, 8'h05, 32'h1, 1'b0);

        do_reset();

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].addr, tbl[i].cs, tbl[i].wn, tbl[i].wd, tbl[i].inp);
            check($sformatf("tbl_rd[%0d]", i), rdv[0], tbl[i].erd);
            check($sformatf("tbl_irq[%0d]", i), {31'h0, irqv[0]}, {31'h0, tbl[i].eirq});
        end

        // Edge detected on the same edge as a clear of that bit.
        repeat (4) rd(2'd0, 8'h01);
        wr(2'd3, 32'hFF, 8'h01);
        rd(2'd0, 8'h05);
        rd(2'd0, 8'h05);
        wr(2'd3, 32'h04, 8'h05);
        rd(2'd3, 8'h05);
        check("set_wins", rdv[0], 32'h4);

        // Bit 7 rise then fall across the three edge types.
        repeat (4) rd(2'd0, 8'h00);
        wr(2'd3, 32'hFF, 8'h00);
        repeat (4) rd(2'd0, 8'h80);
        rd(2'd3, 8'h80);
        check("rise_main", rdv[0], 32'h80);
        check("rise_fall", rdv[1], 32'h00);
        check("rise_any", rdv[2], 32'h80);
        wr(2'd3, 32'hFF, 8'h80);
        repeat (4) rd(2'd0, 8'h00);
        rd(2'd3, 8'h00);
        check("fall_main", rdv[0], 32'h00);
        check("fall_fall", rdv[1], 32'h80);
        check("fall_any", rdv[2], 32'h80);

        // Pending captures under a full mask, then reset mid-cycle.
        wr(2'd2, 32'hFF, 8'h00);
        repeat (4) rd(2'd0, 8'hFF);
        rd(2'd3, 8'hFF);
        check("pre_rst_irq", {31'h0, irqv[0]}, 32'h1);
        check("pre_rst_rd", rdv[0], 32'hFF);
        do_reset();

        // Levels held through reset must not be captured.
        repeat (10) rd(2'd3, 8'hFF);
        rd(2'd3, 8'hFF);
        check("held_ec", rdv[0], 32'h0);
        check("held_irq", {31'h0, irqv[0]}, 32'h0);
        rd(2'd0, 8'hFF);
        check("held_data", rdv[0], 32'hFF);

        rp = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0)
                rp = 8'($urandom);
            ra = 2'($urandom);
            rc = 1'($urandom);
            rw = ($urandom_range(3) != 0);
            rdat = $urandom;
            step(ra, rc, rw, rdat, rp);
            if (i == 200)
                do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pio_button.md
PIO_BUTTON -- requirements
Module: pio_button

Interface
REQ-001 SHALL have parameter WIDTH, default 8, input port width (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on in_port (2..4).
REQ-003 SHALL have parameter EDGE_TYPE, default 0, edge captured per bit: 0 rising, 1 falling, 2 any.
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port address  input  2  Avalon-MM slave word address.
REQ-007 SHALL have port chipselect  input  1  slave select.
REQ-008 SHALL have port write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-009 SHALL have port writedata  input  32  write data.
REQ-010 SHALL have port in_port  input  WIDTH  asynchronous external inputs (buttons/switches).
REQ-011 SHALL have port readdata  output  32  registered read data, read latency 1.
REQ-012 SHALL have port irq  output  1  active-high level interrupt.

Function
REQ-013 Register map SHALL be: addr 0 data (RO), addr 1 reserved (reads 0, writes ignored), addr 2 irq_mask (RW, WIDTH bits), addr 3 edge_capture (read; write-1-to-clear).
REQ-014 in_port SHALL pass through a SYNC_STAGES-deep flop chain; sync_out is the last stage; no other logic samples in_port.
REQ-015 A prev register SHALL hold sync_out delayed one clk; per-bit edge = sync_out&~prev (rising), ~sync_out&prev (falling), sync_out^prev (any).
REQ-016 An edge on bit i SHALL set edge_capture[i] on the clk edge at which it is detected; bit stays set until cleared by write or reset.
REQ-017 Latency: in_port change setting up before clk edge k SHALL appear in sync_out after edge k+SYNC_STAGES-1 and set edge_capture after edge k+SYNC_STAGES.
REQ-018 Write (chipselect=1, write_n=0) to addr 3 SHALL clear edge_capture[i] for each writedata[i]=1; bits with writedata[i]=0 unchanged.
REQ-019 Simultaneous edge detection and clear on the same bit in the same cycle: set SHALL win (edge never lost).
REQ-020 Write to addr 2 SHALL load irq_mask <= writedata[WIDTH-1:0] on that clk edge; writes to addr 0/1 ignored.
REQ-021 readdata SHALL be registered every clk from the mux of current address: addr 0 sync_out, 1 zero, 2 irq_mask, 3 edge_capture, zero-extended to 32 bits; unused bits always 0.
REQ-022 Reads SHALL have no side effects (reading edge_capture does not clear it).
REQ-023 irq SHALL equal OR of (edge_capture & irq_mask), driven from registers only (no in_port combinational path); it rises the cycle edge_capture/irq_mask update.
REQ-024 An arm counter SHALL inhibit edge_capture setting for the first SYNC_STAGES+1 clk edges after reset_n deassert, so input levels held through reset produce no capture.
REQ-025 in_port pulses shorter than one clk period are not guaranteed to be captured; stable levels of at least 2 clk are.

Reset
REQ-026 On reset_n=0 SHALL immediately clear: sync chain, prev, edge_capture, irq_mask, arm counter, readdata (0), irq (0).
REQ-027 Reset asserted mid-operation SHALL discard pending captures and mask; state after release equals power-up state.

Verification
REQ-028 Defaults, in_port=0x00, wait 5 clk, drive 0x05; wait 2 clk -> read addr 3 returns 0x05; read addr 0 returns 0x05.
REQ-029 Mask=0x01 written, edge_capture=0x05 -> irq=1; write 0x01 to addr 3 -> edge_capture=0x04, irq=0 next cycle.
REQ-030 in_port bit 2 rising in same cycle as write 0x04 to addr 3 reaching that bit -> edge_capture[2] remains 1.
REQ-031 in_port=0xFF held through reset and 10 clk after release -> edge_capture=0x00, irq=0, addr 0 reads 0xFF.
REQ-032 EDGE_TYPE=2, toggle bit 7 high then low 4 clk apart, clear between -> edge_capture[7] set twice; EDGE_TYPE=1 captures only the fall.
REQ-033 Assert reset_n low mid-cycle with mask=0xFF, captures pending -> irq and readdata drop to 0 without clk edge.
